// File: rtl/unidade_mult_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and the default operand width.
package unidade_mult_div_pkg;

    localparam int LARGURA_PADRAO = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CALC   = 2'd1,
        AJUSTE = 2'd2
    } estado_t;

endpackage

// File: rtl/unidade_mult_div_nucleo_iterativo.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring
// shift-subtract divide on a {high, low} accumulator, selected by eh_div.
module nucleo_iterativo
    import unidade_mult_div_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic                   eh_div,
    input  logic [2*LARGURA-1:0]   acc_atual,
    input  logic [LARGURA-1:0]     operando,
    output logic [2*LARGURA-1:0]   acc_prox
);

    logic [LARGURA:0] soma;
    logic [LARGURA:0] tentativa;

    always_comb begin
        soma      = {1'b0, acc_atual[2*LARGURA-1:LARGURA]}
                  + (acc_atual[0] ? {1'b0, operando} : {(LARGURA+1){1'b0}});
        // Partial remainder shifted left by one, then trial-subtract the divisor;
        // bit LARGURA of the difference is the borrow.
        tentativa = {acc_atual[2*LARGURA-1:LARGURA], acc_atual[LARGURA-1]}
                  - {1'b0, operando};
        acc_prox  = {soma, acc_atual[LARGURA-1:1]};
        if (eh_div) begin
            if (!tentativa[LARGURA]) begin
                acc_prox = {tentativa[LARGURA-1:0], acc_atual[LARGURA-2:0], 1'b1};
            end else begin
                acc_prox = {acc_atual[2*LARGURA-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/unidade_mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit with internal HI/LO registers.
// Optional MTHI/MTLO write ports are enabled by defining MTHI_MTLO_EN.
module unidade_mult_div
    import unidade_mult_div_pkg::*;
#(
    parameter int LARGURA   = LARGURA_PADRAO,
    parameter int CONT_BITS = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inicio,
    input  logic [1:0]         operacao,
    input  logic [LARGURA-1:0] Valor_Reg1,
    input  logic [LARGURA-1:0] Valor_Reg2,
`ifdef MTHI_MTLO_EN
    input  logic               escreve_hi,
    input  logic               escreve_lo,
    input  logic [LARGURA-1:0] dado_mt,
`endif
    output logic [LARGURA-1:0] HI,
    output logic [LARGURA-1:0] LO,
    output logic               ocupado,
    output logic               pronto,
    output logic               div_zero
);

    localparam logic [CONT_BITS-1:0] ULTIMA_ITER = CONT_BITS'(LARGURA - 1);

    estado_t                estado, proximo;
    logic [CONT_BITS-1:0]   contador;
    logic [1:0]             op_reg;
    logic [2*LARGURA-1:0]   acc, acc_prox, produto;
    logic [LARGURA-1:0]     operando_b, quociente, resto, hi_novo, lo_novo;
    logic [LARGURA-1:0]     mag1, mag2;
    logic                   sinal1, sinal2, com_sinal_in, eh_div_in, eh_div;
    logic                   sinal_res, sinal_dividendo, divisor_zero;

    assign eh_div_in    = (operacao == OP_DIV) || (operacao == OP_DIVU);
    assign com_sinal_in = (operacao == OP_MULT) || (operacao == OP_DIV);
    assign sinal1       = com_sinal_in & Valor_Reg1[LARGURA-1];
    assign sinal2       = com_sinal_in & Valor_Reg2[LARGURA-1];
    assign mag1         = sinal1 ? -Valor_Reg1 : Valor_Reg1;
    assign mag2         = sinal2 ? -Valor_Reg2 : Valor_Reg2;
    assign eh_div       = (op_reg == OP_DIV) || (op_reg == OP_DIVU);
    assign ocupado      = (estado != OCIOSO);

    nucleo_iterativo #(.LARGURA(LARGURA)) u_nucleo (
        .eh_div    (eh_div),
        .acc_atual (acc),
        .operando  (operando_b),
        .acc_prox  (acc_prox)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= OCIOSO;
        else        estado <= proximo;
    end

    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:  if (inicio) proximo = CALC;
            CALC:    if (contador == ULTIMA_ITER) proximo = AJUSTE;
            AJUSTE:  proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    // Sign fix-up; a zero divisor forces an all-ones quotient while the remainder
    // path naturally reproduces the dividend.
    always_comb begin
        quociente = acc[LARGURA-1:0];
        resto     = acc[2*LARGURA-1:LARGURA];
        produto   = sinal_res ? -acc : acc;
        hi_novo   = produto[2*LARGURA-1:LARGURA];
        lo_novo   = produto[LARGURA-1:0];
        if (eh_div) begin
            hi_novo = sinal_dividendo ? -resto : resto;
            lo_novo = sinal_res ? -quociente : quociente;
            if (divisor_zero) lo_novo = {LARGURA{1'b1}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contador        <= '0;
            op_reg          <= OP_MULT;
            acc             <= '0;
            operando_b      <= '0;
            sinal_res       <= 1'b0;
            sinal_dividendo <= 1'b0;
            divisor_zero    <= 1'b0;
            HI              <= '0;
            LO              <= '0;
            pronto          <= 1'b0;
            div_zero        <= 1'b0;
        end else begin
            pronto <= (estado == AJUSTE);
            case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        op_reg          <= operacao;
                        contador        <= '0;
                        div_zero        <= 1'b0;
                        sinal_res       <= sinal1 ^ sinal2;
                        sinal_dividendo <= sinal1 & eh_div_in;
                        divisor_zero    <= (Valor_Reg2 == '0);
                        acc             <= {{LARGURA{1'b0}}, (eh_div_in ? mag1 : mag2)};
                        operando_b      <= eh_div_in ? mag2 : mag1;
                    end
`ifdef MTHI_MTLO_EN
                    else begin
                        if (escreve_hi) HI <= dado_mt;
                        if (escreve_lo) LO <= dado_mt;
                    end
`endif
                end
                CALC: begin
                    acc      <= acc_prox;
                    contador <= contador + 1'b1;
                end
                AJUSTE: begin
                    HI       <= hi_novo;
                    LO       <= lo_novo;
                    div_zero <= eh_div & divisor_zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_mult_div.sv
// Self-checking bench for unidade_mult_div: reference model feeds an expected
// queue, a monitor compares HI/LO/div_zero on every pronto pulse.
module tb_unidade_mult_div;
    import unidade_mult_div_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         inicio = 1'b0;
    logic [1:0]   operacao = 2'b00;
    logic [W-1:0] Valor_Reg1 = '0;
    logic [W-1:0] Valor_Reg2 = '0;
    logic         escreve_hi = 1'b0;
    logic         escreve_lo = 1'b0;
    logic [W-1:0] dado_mt = '0;
    logic [W-1:0] HI, LO;
    logic         ocupado, pronto, div_zero;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_hi_q[$];
    logic [W-1:0] exp_lo_q[$];
    logic [W-1:0] exp_dz_q[$];
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;
    logic         pronto_ant = 1'b0;

    always #5 clk = ~clk;

    unidade_mult_div dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inicio     (inicio),
        .operacao   (operacao),
        .Valor_Reg1 (Valor_Reg1),
        .Valor_Reg2 (Valor_Reg2),
`ifdef MTHI_MTLO_EN
        .escreve_hi (escreve_hi),
        .escreve_lo (escreve_lo),
        .dado_mt    (dado_mt),
`endif
        .HI         (HI),
        .LO         (LO),
        .ocupado    (ocupado),
        .pronto     (pronto),
        .div_zero   (div_zero)
    );

    task automatic verifica(input string tag, input logic [W-1:0] obtido, input logic [W-1:0] esperado);
        checks++;
        if (obtido !== esperado) begin
            errors++;
            $display("FAIL %s: obtido=%h esperado=%h", tag, obtido, esperado);
        end
    endtask

    task automatic modelo(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] eh, output logic [W-1:0] el, output logic edz);
        longint       sa, sb, p;
        logic [63:0]  pu;
        int           ia, ib;
        ia = a;
        ib = b;
        sa = longint'(ia);
        sb = longint'(ib);
        edz = 1'b0;
        case (op)
            OP_MULT: begin
                p  = sa * sb;
                eh = p[63:32];
                el = p[31:0];
            end
            OP_MULTU: begin
                pu = {32'b0, a} * {32'b0, b};
                eh = pu[63:32];
                el = pu[31:0];
            end
            OP_DIV: begin
                if (b == 0) begin
                    el = '1; eh = a; edz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000; eh = '0;
                end else begin
                    el = ia / ib;
                    eh = ia % ib;
                end
            end
            default: begin
                if (b == 0) begin
                    el = '1; eh = a; edz = 1'b1;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endtask

    // pk: cycle offsets after acceptance at which inicio (p1/p2) or an MT write (pmt) is pulsed
    task automatic executa(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int p1 = -1, input int p2 = -1, input int pmt = -1);
        logic [W-1:0] eh, el;
        logic         edz;
        int           n_ocup;
        modelo(op, a, b, eh, el, edz);
        exp_hi_q.push_back(eh);
        exp_lo_q.push_back(el);
        exp_dz_q.push_back({31'b0, edz});
        last_hi = eh;
        last_lo = el;
        @(negedge clk);
        inicio = 1'b1; operacao = op; Valor_Reg1 = a; Valor_Reg2 = b;
        @(negedge clk);
        inicio = 1'b0;
        n_ocup = 0;
        for (int k = 0; k < 33; k++) begin
            if (ocupado) n_ocup++;
            inicio = (k == p1) || (k == p2);
            if (inicio) begin
                operacao = 2'($urandom_range(0, 3));
                Valor_Reg1 = $urandom;
                Valor_Reg2 = $urandom;
            end
            escreve_hi = (k == pmt);
            escreve_lo = (k == pmt);
            dado_mt = $urandom;
            @(negedge clk);
        end
        inicio = 1'b0; escreve_hi = 1'b0; escreve_lo = 1'b0;
        verifica("latencia_pronto", {31'b0, pronto}, 1);
        verifica("ocupado_fim", {31'b0, ocupado}, 0);
        verifica("ciclos_ocupado", W'(n_ocup), 33);
    endtask

    always @(negedge clk) begin
        if (rst_n && pronto) begin
            verifica("pronto_um_ciclo", {31'b0, pronto_ant}, 0);
            verifica("fila_no_pronto", W'(exp_hi_q.size() != 0), 1);
            if (exp_hi_q.size() != 0) begin
                verifica("hi", HI, exp_hi_q.pop_front());
                verifica("lo", LO, exp_lo_q.pop_front());
                verifica("div_zero", {31'b0, div_zero}, exp_dz_q.pop_front());
            end
        end
        pronto_ant <= pronto;
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        verifica("reset_hi", HI, 0);
        verifica("reset_lo", LO, 0);
        verifica("reset_ocupado", {31'b0, ocupado}, 0);
        verifica("reset_pronto", {31'b0, pronto}, 0);
        verifica("reset_div_zero", {31'b0, div_zero}, 0);
        rst_n = 1'b1;

        executa(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        executa(OP_MULT, -32'sd7, 32'd3);
        executa(OP_DIV, -32'sd7, 32'd2);
        executa(OP_DIVU, 32'd100, 32'd0);
        executa(OP_MULTU, 32'd2, 32'd3);
        executa(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        executa(OP_DIV, -32'sd50, 32'd0);
        executa(OP_DIV, 32'd7, -32'sd2);
        executa(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        executa(OP_DIVU, 32'd1000, 32'd7, 5, 20);

        // HI/LO must hold while operands wander
        repeat (4) begin
            @(negedge clk);
            Valor_Reg1 = $urandom; Valor_Reg2 = $urandom; operacao = 2'($urandom_range(0, 3));
        end
        verifica("hold_hi", HI, last_hi);
        verifica("hold_lo", LO, last_lo);

        // Asynchronous reset in the middle of a MULT
        @(negedge clk);
        inicio = 1'b1; operacao = OP_MULT; Valor_Reg1 = -32'sd9; Valor_Reg2 = 32'd11;
        @(negedge clk);
        inicio = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        verifica("rst_meio_hi", HI, 0);
        verifica("rst_meio_lo", LO, 0);
        verifica("rst_meio_ocupado", {31'b0, ocupado}, 0);
        verifica("rst_meio_pronto", {31'b0, pronto}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        verifica("rst_sem_pronto_lo", LO, 0);
        executa(OP_MULTU, 32'd4, 32'd5);

        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] b;
            b = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
            if ($urandom_range(0, 2) == 0) b = W'($urandom_range(1, 20));
            executa(2'($urandom_range(0, 3)), $urandom, b);
        end

`ifdef MTHI_MTLO_EN
        @(negedge clk);
        escreve_hi = 1'b1; dado_mt = 32'h1234;
        @(negedge clk);
        escreve_hi = 1'b0;
        verifica("mthi", HI, 32'h1234);
        verifica("mthi_lo_inalterado", LO, last_lo);
        executa(OP_MULTU, 32'd2, 32'd3, -1, -1, 10);
`endif

        repeat (3) @(negedge clk);
        verifica("fila_final", W'(exp_hi_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
